// File: rtl/wb_regfile_if.sv
// Writeback/register-file bus: MEM-stage writeback inputs, decode read ports, commit status.
// The master drives writeback and read addresses; the slave (wb_regfile) returns data and status.
interface wb_regfile_if #(
   parameter int DSIZE = 16,
   parameter int ASIZE = 4,
   parameter int CNTW  = 16
);
   logic [DSIZE-1:0] aluout_in;
   logic [DSIZE-1:0] mem_rdata_in;
   logic [ASIZE-1:0] waddr_in;
   logic             write_en_in;
   logic             mem_to_reg_in;
   logic [ASIZE-1:0] raddr1;
   logic [ASIZE-1:0] raddr2;
   logic [DSIZE-1:0] rdata1;
   logic [DSIZE-1:0] rdata2;
   logic [DSIZE-1:0] wb_data;
   logic             commit;
   logic [CNTW-1:0]  commit_cnt;

   modport master (
      output aluout_in, mem_rdata_in, waddr_in, write_en_in, mem_to_reg_in,
      output raddr1, raddr2,
      input  rdata1, rdata2, wb_data, commit, commit_cnt
   );

   modport slave (
      input  aluout_in, mem_rdata_in, waddr_in, write_en_in, mem_to_reg_in,
      input  raddr1, raddr2,
      output rdata1, rdata2, wb_data, commit, commit_cnt
   );
endinterface

// File: rtl/wb_regfile.sv
// Writeback select, architectural register file with two combinational read ports and a
// saturating commit counter. Define WB_BYPASS_EN for same-cycle write-to-read forwarding.
module wb_regfile #(
   parameter int DSIZE = 16,
   parameter int ASIZE = 4,
   parameter int CNTW  = 16
) (
   input  logic         clk,
   input  logic         rst,
   wb_regfile_if.slave  bus
);
   localparam int DEPTH = 1 << ASIZE;

   logic [DEPTH-1:0][DSIZE-1:0] regs_q, regs_d;
   logic [CNTW-1:0]             cnt_q, cnt_d;
   logic [DSIZE-1:0]            wb_data;
   logic                        commit;

   logic [1:0][ASIZE-1:0]       raddr;
   logic [1:0][DSIZE-1:0]       rdata;

   assign wb_data = bus.mem_to_reg_in ? bus.mem_rdata_in : bus.aluout_in;
   // Address 0 is never written, so entry 0 of the array stays zero out of reset.
   assign commit  = bus.write_en_in && (bus.waddr_in != '0) && !rst;

   always_comb begin
      regs_d = regs_q;
      cnt_d  = cnt_q;
      if (commit) begin
         regs_d[bus.waddr_in] = wb_data;
         if (cnt_q != {CNTW{1'b1}}) begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         regs_q <= '0;
         cnt_q  <= '0;
      end else begin
         regs_q <= regs_d;
         cnt_q  <= cnt_d;
      end
   end

   assign raddr[0] = bus.raddr1;
   assign raddr[1] = bus.raddr2;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_rport
         always_comb begin
            rdata[gi] = regs_q[raddr[gi]];
            if (raddr[gi] == '0) begin
               rdata[gi] = '0;
            end
`ifdef WB_BYPASS_EN
            else if (commit && (raddr[gi] == bus.waddr_in)) begin
               rdata[gi] = wb_data;
            end
`endif
         end
      end
   endgenerate

   assign bus.rdata1     = rdata[0];
   assign bus.rdata2     = rdata[1];
   assign bus.wb_data    = wb_data;
   assign bus.commit     = commit;
   assign bus.commit_cnt = cnt_q;
endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: a reference model feeds a queue of expected read values
// that are popped and compared when the DUT outputs are sampled.
module tb_wb_regfile;
   localparam int DSIZE = 16;
   localparam int ASIZE = 4;
   localparam int CNTW  = 4;

   logic clk;
   logic rst;

   wb_regfile_if #(.DSIZE(DSIZE), .ASIZE(ASIZE), .CNTW(CNTW)) bus ();

   wb_regfile #(.DSIZE(DSIZE), .ASIZE(ASIZE), .CNTW(CNTW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests_run = 0;
   int tests_failed = 0;

   logic [DSIZE-1:0] model_regs [16];
   logic [CNTW-1:0]  model_cnt;
   logic [DSIZE-1:0] exp_q [$];

   task automatic model_clear();
      for (int i = 0; i < 16; i++) model_regs[i] = '0;
      model_cnt = '0;
   endtask

   task automatic apply_reset(input int ncyc);
      rst = 1'b1;
      bus.write_en_in = 1'b0;
      repeat (ncyc) begin
         @(posedge clk);
         #1;
      end
      rst = 1'b0;
      model_clear();
   endtask

   task automatic do_write(input logic [3:0] a, input logic [15:0] alu,
                           input logic [15:0] mem, input logic m2r);
      bus.waddr_in      = a;
      bus.aluout_in     = alu;
      bus.mem_rdata_in  = mem;
      bus.mem_to_reg_in = m2r;
      bus.write_en_in   = 1'b1;
      @(posedge clk);
      #1;
      bus.write_en_in   = 1'b0;
      if (a != 4'd0) begin
         model_regs[a] = m2r ? mem : alu;
         if (model_cnt != 4'hF) model_cnt = model_cnt + 1'b1;
      end
   endtask

   task automatic test_reset();
      logic [15:0] e;
      apply_reset(2);
      for (int a = 0; a < 16; a++) begin
         bus.raddr1 = 4'(a);
         bus.raddr2 = 4'(15 - a);
         exp_q.push_back(16'h0000);
         exp_q.push_back(16'h0000);
         #1;
         e = exp_q.pop_front();
         tests_run++;
         if (bus.rdata1 !== e) begin
            tests_failed++;
            $display("FAIL reset_rdata1 addr=%0d got=%h exp=%h", a, bus.rdata1, e);
         end
         e = exp_q.pop_front();
         tests_run++;
         if (bus.rdata2 !== e) begin
            tests_failed++;
            $display("FAIL reset_rdata2 addr=%0d got=%h exp=%h", 15 - a, bus.rdata2, e);
         end
      end
      tests_run++;
      if (bus.commit_cnt !== 4'd0) begin
         tests_failed++;
         $display("FAIL reset_cnt got=%0d exp=0", bus.commit_cnt);
      end
      $display("[TB] reset: array swept, commit_cnt=%0d", bus.commit_cnt);
   endtask

   task automatic test_select();
      logic [15:0] e;
      bus.waddr_in = 4'd3; bus.aluout_in = 16'h1234; bus.mem_rdata_in = 16'hBEEF;
      bus.mem_to_reg_in = 1'b0; bus.write_en_in = 1'b1;
      #1;
      tests_run++;
      if (bus.wb_data !== 16'h1234 || bus.commit !== 1'b1) begin
         tests_failed++;
         $display("FAIL select_alu_comb wb_data=%h commit=%b exp=1234/1", bus.wb_data, bus.commit);
      end
      bus.write_en_in = 1'b0;
      do_write(4'd3, 16'h1234, 16'hBEEF, 1'b0);
      do_write(4'd4, 16'h1234, 16'hBEEF, 1'b1);
      bus.raddr1 = 4'd3;
      bus.raddr2 = 4'd4;
      exp_q.push_back(model_regs[3]);
      exp_q.push_back(model_regs[4]);
      #1;
      e = exp_q.pop_front();
      tests_run++;
      if (bus.rdata1 !== e) begin
         tests_failed++;
         $display("FAIL select_alu r3 got=%h exp=%h", bus.rdata1, e);
      end
      e = exp_q.pop_front();
      tests_run++;
      if (bus.rdata2 !== e) begin
         tests_failed++;
         $display("FAIL select_mem r4 got=%h exp=%h", bus.rdata2, e);
      end
      tests_run++;
      if (bus.commit_cnt !== 4'd2) begin
         tests_failed++;
         $display("FAIL select_cnt got=%0d exp=2", bus.commit_cnt);
      end
      $display("[TB] select: r3=%h r4=%h cnt=%0d", bus.rdata1, bus.rdata2, bus.commit_cnt);
   endtask

   task automatic test_zero_reg();
      logic [CNTW-1:0] cnt_before;
      cnt_before = model_cnt;
      bus.waddr_in = 4'd0; bus.aluout_in = 16'hFFFF; bus.mem_to_reg_in = 1'b0;
      bus.write_en_in = 1'b1; bus.raddr1 = 4'd0;
      #1;
      tests_run++;
      if (bus.commit !== 1'b0 || bus.rdata1 !== 16'h0000) begin
         tests_failed++;
         $display("FAIL zero_comb commit=%b rdata1=%h exp=0/0000", bus.commit, bus.rdata1);
      end
      do_write(4'd0, 16'hFFFF, 16'h0000, 1'b0);
      tests_run++;
      if (bus.rdata1 !== 16'h0000) begin
         tests_failed++;
         $display("FAIL zero_read got=%h exp=0000", bus.rdata1);
      end
      tests_run++;
      if (bus.commit_cnt !== cnt_before) begin
         tests_failed++;
         $display("FAIL zero_cnt got=%0d exp=%0d", bus.commit_cnt, cnt_before);
      end
      $display("[TB] zero_reg: rdata1=%h cnt=%0d", bus.rdata1, bus.commit_cnt);
   endtask

   task automatic test_bypass();
      logic [15:0] e;
      do_write(4'd5, 16'h0001, 16'h0000, 1'b0);
      bus.waddr_in = 4'd5; bus.aluout_in = 16'hA5A5; bus.mem_to_reg_in = 1'b0;
      bus.write_en_in = 1'b1; bus.raddr1 = 4'd5; bus.raddr2 = 4'd5;
`ifdef WB_BYPASS_EN
      exp_q.push_back(16'hA5A5);
      exp_q.push_back(16'hA5A5);
`else
      exp_q.push_back(16'h0001);
      exp_q.push_back(16'h0001);
`endif
      #1;
      e = exp_q.pop_front();
      tests_run++;
      if (bus.rdata1 !== e) begin
         tests_failed++;
         $display("FAIL bypass_same_cycle_p1 got=%h exp=%h", bus.rdata1, e);
      end
      e = exp_q.pop_front();
      tests_run++;
      if (bus.rdata2 !== e) begin
         tests_failed++;
         $display("FAIL bypass_same_cycle_p2 got=%h exp=%h", bus.rdata2, e);
      end
      bus.write_en_in = 1'b0;
      do_write(4'd5, 16'hA5A5, 16'h0000, 1'b0);
      exp_q.push_back(model_regs[5]);
      #1;
      e = exp_q.pop_front();
      tests_run++;
      if (bus.rdata1 !== e || bus.rdata2 !== e) begin
         tests_failed++;
         $display("FAIL bypass_next_cycle got=%h/%h exp=%h", bus.rdata1, bus.rdata2, e);
      end
      $display("[TB] bypass: r5 next cycle=%h/%h", bus.rdata1, bus.rdata2);
   endtask

   task automatic test_reset_collision();
      do_write(4'd2, 16'h2222, 16'h0000, 1'b0);
      rst = 1'b1;
      bus.waddr_in = 4'd6; bus.aluout_in = 16'h7777; bus.mem_to_reg_in = 1'b0;
      bus.write_en_in = 1'b1;
      #1;
      tests_run++;
      if (bus.commit !== 1'b0 || bus.wb_data !== 16'h7777) begin
         tests_failed++;
         $display("FAIL collision_comb commit=%b wb_data=%h exp=0/7777", bus.commit, bus.wb_data);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.write_en_in = 1'b0;
      model_clear();
      bus.raddr1 = 4'd6; bus.raddr2 = 4'd2;
      #1;
      tests_run++;
      if (bus.rdata1 !== model_regs[6] || bus.rdata2 !== model_regs[2]) begin
         tests_failed++;
         $display("FAIL collision_regs r6=%h r2=%h exp=0000/0000", bus.rdata1, bus.rdata2);
      end
      tests_run++;
      if (bus.commit_cnt !== 4'd0) begin
         tests_failed++;
         $display("FAIL collision_cnt got=%0d exp=0", bus.commit_cnt);
      end
      do_write(4'd7, 16'h0BAD, 16'h0000, 1'b0);
      bus.raddr1 = 4'd7;
      #1;
      tests_run++;
      if (bus.rdata1 !== 16'h0BAD || bus.commit_cnt !== 4'd1) begin
         tests_failed++;
         $display("FAIL post_reset_write r7=%h cnt=%0d exp=0bad/1", bus.rdata1, bus.commit_cnt);
      end
      $display("[TB] reset_collision: r6/r2 cleared, r7=%h", bus.rdata1);
   endtask

   task automatic test_saturation();
      apply_reset(1);
      bus.raddr1 = 4'd1;
      for (int i = 0; i < 20; i++) begin
         do_write(4'd1, 16'(16'h0100 + i), 16'h0000, 1'b0);
         tests_run++;
         if (bus.commit_cnt !== model_cnt) begin
            tests_failed++;
            $display("FAIL sat_cnt step=%0d got=%0d exp=%0d", i, bus.commit_cnt, model_cnt);
         end
      end
      tests_run++;
      if (bus.commit_cnt !== 4'hF || bus.rdata1 !== 16'h0113) begin
         tests_failed++;
         $display("FAIL sat_final cnt=%0d r1=%h exp=15/0113", bus.commit_cnt, bus.rdata1);
      end
      $display("[TB] saturation: cnt=%0d r1=%h", bus.commit_cnt, bus.rdata1);
   endtask

   task automatic test_back_to_back();
      logic [15:0] e;
      apply_reset(1);
      for (int i = 0; i < 40; i++) begin
         do_write(4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom), 1'($urandom));
      end
      for (int a = 0; a < 16; a++) begin
         bus.raddr1 = 4'(a);
         bus.raddr2 = 4'(a ^ 5);
         exp_q.push_back(model_regs[a]);
         exp_q.push_back(model_regs[a ^ 5]);
         #1;
         e = exp_q.pop_front();
         tests_run++;
         if (bus.rdata1 !== e) begin
            tests_failed++;
            $display("FAIL b2b_rdata1 addr=%0d got=%h exp=%h", a, bus.rdata1, e);
         end
         e = exp_q.pop_front();
         tests_run++;
         if (bus.rdata2 !== e) begin
            tests_failed++;
            $display("FAIL b2b_rdata2 addr=%0d got=%h exp=%h", a ^ 5, bus.rdata2, e);
         end
      end
      tests_run++;
      if (bus.commit_cnt !== model_cnt) begin
         tests_failed++;
         $display("FAIL b2b_cnt got=%0d exp=%0d", bus.commit_cnt, model_cnt);
      end
      $display("[TB] back_to_back: cnt=%0d", bus.commit_cnt);
   endtask

   initial begin
      rst = 1'b1;
      bus.aluout_in = '0; bus.mem_rdata_in = '0; bus.waddr_in = '0;
      bus.write_en_in = 1'b0; bus.mem_to_reg_in = 1'b0;
      bus.raddr1 = '0; bus.raddr2 = '0;
      model_clear();
      test_reset();
      test_select();
      test_zero_reg();
      test_bypass();
      test_reset_collision();
      test_saturation();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
